// File: rtl/hazard_controller.sv
// Hazard controller for the 5-stage pipeline: operand forwarding, load-use stalls,
// branch squashing and a memory-wait freeze with stall counter and sticky timeout.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_RUN      | normal issue; forwarding, load-use and branch flushes active
// S_MEM_WAIT | data-memory access pending; whole pipeline frozen until ack/timeout
module hazard_controller #(
    parameter int DATA_ADDR_W = 4,
    parameter int TIMEOUT     = 64,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_ADDR_W-1:0] ra1_d,
    input  logic [DATA_ADDR_W-1:0] ra2_d,
    input  logic [DATA_ADDR_W-1:0] ra3_d,
    input  logic [DATA_ADDR_W-1:0] ra1_e,
    input  logic [DATA_ADDR_W-1:0] ra2_e,
    input  logic [DATA_ADDR_W-1:0] ra3_e,
    input  logic [DATA_ADDR_W-1:0] wa_e,
    input  logic [DATA_ADDR_W-1:0] wa_m,
    input  logic [DATA_ADDR_W-1:0] wa_w,
    input  logic                   reg_write_e,
    input  logic                   reg_write_m,
    input  logic                   reg_write_w,
    input  logic                   mem_read_e,
    input  logic                   branch_taken_e,
    input  logic                   mem_req_m,
    input  logic                   mem_ack,
    output logic [1:0]             forward_a_e,
    output logic [1:0]             forward_b_e,
    output logic [1:0]             forward_c_e,
    output logic                   stall_f,
    output logic                   stall_d,
    output logic                   stall_e,
    output logic                   stall_m,
    output logic                   flush_d,
    output logic                   flush_e,
    output logic                   flush_w,
    output logic [CNT_W-1:0]       stall_count,
    output logic                   mem_timeout
);

    localparam int WCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [DATA_ADDR_W-1:0] PC_REG   = '1;
    localparam logic [WCNT_W-1:0]      WAIT_MAX = WCNT_W'(TIMEOUT - 1);

    typedef enum logic {S_RUN, S_MEM_WAIT} state_t;

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic ldstall;
    logic freeze_req;

    function automatic logic [1:0] fwd_sel(
        input logic [DATA_ADDR_W-1:0] ra,
        input logic                   rw_m,
        input logic [DATA_ADDR_W-1:0] a_m,
        input logic                   rw_w,
        input logic [DATA_ADDR_W-1:0] a_w
    );
        if (ra == PC_REG)            return 2'b00;
        else if (rw_m && a_m == ra)  return 2'b10;
        else if (rw_w && a_w == ra)  return 2'b01;
        else                         return 2'b00;
    endfunction

    assign ldstall = mem_read_e && reg_write_e && (wa_e != PC_REG) &&
                     ((wa_e == ra1_d) || (wa_e == ra2_d) || (wa_e == ra3_d));
    assign freeze_req = mem_req_m && !mem_ack;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_RUN;
            wcnt_q      <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // wcnt_q counts stall cycles of the current access, including the entry cycle in S_RUN.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        timeout_d = timeout_q;
        case (state_q)
            S_RUN: begin
                if (freeze_req) begin
                    state_d = S_MEM_WAIT;
                    wcnt_d  = WCNT_W'(1);
                end
            end
            S_MEM_WAIT: begin
                if (mem_ack || !mem_req_m) begin
                    state_d = S_RUN;
                    wcnt_d  = '0;
                end else if (wcnt_q >= WAIT_MAX) begin
                    state_d   = S_RUN;
                    wcnt_d    = '0;
                    timeout_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            default: begin
                state_d = S_RUN;
                wcnt_d  = '0;
            end
        endcase
        stall_cnt_d = (stall_f && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    end

    always_comb begin
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_e     = 1'b0;
        stall_m     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        flush_w     = 1'b0;
        forward_a_e = 2'b00;
        forward_b_e = 2'b00;
        forward_c_e = 2'b00;
        if (!rst) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_w = 1'b1;
        end else begin
            forward_a_e = fwd_sel(ra1_e, reg_write_m, wa_m, reg_write_w, wa_w);
            forward_b_e = fwd_sel(ra2_e, reg_write_m, wa_m, reg_write_w, wa_w);
            forward_c_e = fwd_sel(ra3_e, reg_write_m, wa_m, reg_write_w, wa_w);
            if (state_q == S_MEM_WAIT || freeze_req) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end else if (branch_taken_e) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (ldstall) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    assign stall_count = stall_cnt_q;
    assign mem_timeout = timeout_q;

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline scheduler for the 5-stage processor (fetch, decode, execute, memory, write-back).
- Selects operand forwarding for the execute stage and detects load-use hazards.
- Squashes wrong-path instructions when a branch is taken in execute.
- Freezes the pipeline while a multi-cycle data-memory access waits for its acknowledge, and keeps a stall-cycle counter plus a sticky memory-timeout flag.

Parameters:
- DATA_ADDR_W, 4, register address width (16 registers; R15 = PC, never forwarded).
- TIMEOUT, 64, maximum MEM_WAIT cycles before timeout is flagged.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-low reset.
- ra1_d, ra2_d, ra3_d  in  4  decode-stage source register addresses.
- ra1_e, ra2_e, ra3_e  in  4  execute-stage source register addresses.
- wa_e, wa_m, wa_w  in  4  destination address in execute / memory / write-back.
- reg_write_e, reg_write_m, reg_write_w  in  1  destination valid per stage.
- mem_read_e  in  1  execute-stage instruction is a load.
- branch_taken_e  in  1  branch resolved taken in execute.
- mem_req_m  in  1  memory-stage access in progress.
- mem_ack  in  1  data memory completes the access this cycle.
- forward_a_e, forward_b_e, forward_c_e  out  2  00 register file, 01 write-back result, 10 memory-stage ALU result.
- stall_f, stall_d, stall_e, stall_m  out  1  hold the pipeline register feeding that stage.
- flush_d, flush_e, flush_w  out  1  insert a bubble into that stage's register.
- stall_count  out  CNT_W  saturating count of cycles with stall_f = 1.
- mem_timeout  out  1  sticky; set when MEM_WAIT lasts TIMEOUT cycles.

Behaviour:
- Reset (rst = 0 at a clock edge):
  - state <= RUN; stall_count <= 0; mem_timeout <= 0; wait counter <= 0.
  - While rst = 0, outputs are: all stall_* = 0, flush_d = flush_e = flush_w = 1, all forward_* = 00.
- Forwarding (combinational from current inputs), per source rX_e:
  - 10 if reg_write_m and wa_m == rX_e and rX_e != 15.
  - else 01 if reg_write_w and wa_w == rX_e and rX_e != 15.
  - else 00.
  - The memory stage wins when both match.
- FSM states: RUN, MEM_WAIT.
- RUN:
  - Load-use hazard: ldstall = mem_read_e & reg_write_e & (wa_e matches ra1_d, ra2_d or ra3_d) & wa_e != 15.
  - ldstall gives stall_f = stall_d = flush_e = 1 for exactly one cycle; the hazard clears because the load advances.
  - branch_taken_e gives flush_d = flush_e = 1; stall_f = stall_d = 0, so the branch overrides ldstall.
  - If mem_req_m & ~mem_ack: next state MEM_WAIT, and in this cycle stall_f = stall_d = stall_e = stall_m = 1 and flush_w = 1.
  - Memory freeze has highest priority: branch and load-use flushes are suppressed while frozen and re-evaluated after release.
  - If mem_req_m & mem_ack in the same cycle: no stall (zero-wait access).
- MEM_WAIT:
  - stall_f/d/e/m = 1 and flush_w = 1 every cycle.
  - Wait counter increments each cycle.
  - On mem_ack = 1: stalls remain asserted that cycle, the counter clears, and next state is RUN. The next cycle runs normally with flushes re-evaluated.
  - When the wait counter reaches TIMEOUT-1 without an ack: mem_timeout <= 1 (sticky until reset), counter clears, and next state is RUN, releasing the pipeline.
  - mem_req_m dropping to 0 in MEM_WAIT is treated as an abort: next state RUN with no timeout flag.
- stall_count:
  - Increments on each cycle with stall_f = 1.
  - Saturates at all ones and never wraps.
- Reset asserted during MEM_WAIT: returns to RUN immediately at that edge; the stall freeze ends the same cycle rst is sampled low.

Test Plan:
- Forwarding: wa_m = 3 and wa_w = 3, both reg_write, ra1_e = 3 -> forward_a_e = 10; drop reg_write_m -> 01; ra2_e = 15 with wa_m = 15 -> forward_b_e = 00.
- Load-use: mem_read_e = 1, wa_e = 5, ra2_d = 5 -> one cycle of stall_f = stall_d = flush_e = 1; the next cycle with a different instruction in execute -> all 0; stall_count = 1.
- Branch plus load-use in the same cycle: branch_taken_e = 1 and ldstall true -> flush_d = flush_e = 1, stall_f = 0.
- Memory wait: mem_req_m = 1 with mem_ack low for 3 cycles, then high -> stall_f/d/e/m = 1 for 4 cycles, then RUN; stall_count increases by 4; mem_ack high on the first cycle -> no stall.
- Timeout: TIMEOUT = 8, mem_ack held low -> mem_timeout rises after 8 stall cycles, pipeline released, flag held until rst = 0.
- Reset mid-wait: rst = 0 during the 2nd MEM_WAIT cycle -> next cycle is RUN, stall_count = 0, flush_d/e/w = 1 while rst is low.
